// File: rtl/crossbar_pkg.sv
// Shared types and constants for the crossbar slave-port responder.
package crossbar_pkg;

  localparam int DATA_W = 32;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/xbar_sp_ram.sv
// Single-port word RAM: synchronous write, registered read that reads as zero
// whenever no read is being launched, so the output is only non-zero for one cycle.
module xbar_sp_ram
  import crossbar_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_W-1:0] r_rdata;

  // Storage array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Read register: loads on a read launch, otherwise returns to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/crossbar_mem_slave.sv
// Memory-backed target for one crossbar slave port. Captures a held request,
// waits WAIT_CYCLES cycles, performs the access and pulses ack for one cycle.
// A change of address or command while req stays high means a different
// master now owns the port, so the transaction is restarted with its fields.
module crossbar_mem_slave
  import crossbar_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_cmd,
  output logic              o_ack,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  state_t                  r_state;
  state_t                  w_nextState;
  logic [31:0]             r_capAddr;
  logic [DATA_W-1:0]       r_capWdata;
  logic                    r_capCmd;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_nextCount;
  logic                    w_capture;
  logic                    w_doOp;
  logic [DEPTH_LOG2-1:0]   w_opIdx;
  logic [DATA_W-1:0]       w_opWdata;
  logic                    w_opCmd;
  logic                    w_we;
  logic                    w_re;

  // State, wait counter and request capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_capAddr  <= '0;
      r_capWdata <= '0;
      r_capCmd   <= CMD_READ;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      if (w_capture) begin
        r_capAddr  <= i_addr;
        r_capWdata <= i_wdata;
        r_capCmd   <= i_cmd;
      end
    end
  end

  // Next-state logic; w_doOp marks the edge that enters ACK and launches the access.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_capture   = 1'b0;
    w_doOp      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            w_nextState = WAIT;
            w_nextCount = CNT_RELOAD;
          end else begin
            w_nextState = ACK;
            w_doOp      = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!i_req) begin
          w_nextState = IDLE;
        end else if ((i_addr != r_capAddr) || (i_cmd != r_capCmd)) begin
          w_capture   = 1'b1;
          w_nextCount = CNT_RELOAD;
        end else if (r_count == '0) begin
          w_nextState = ACK;
          w_doOp      = 1'b1;
        end else begin
          w_nextCount = r_count - 1'b1;
        end
      end
      ACK: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Access operands: with zero wait states the access happens on the capture
  // edge itself, so the live request fields are used instead of the captured ones.
  always_comb begin
    if (r_state == IDLE) begin
      w_opIdx   = i_addr[DEPTH_LOG2+1:2];
      w_opWdata = i_wdata;
      w_opCmd   = i_cmd;
    end else begin
      w_opIdx   = r_capAddr[DEPTH_LOG2+1:2];
      w_opWdata = r_capWdata;
      w_opCmd   = r_capCmd;
    end
  end

  assign w_we = w_doOp && (w_opCmd == CMD_WRITE);
  assign w_re = w_doOp && (w_opCmd == CMD_READ);

  xbar_sp_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_idx  (w_opIdx),
    .i_wdata(w_opWdata),
    .o_rdata(o_rdata)
  );

  assign o_ack  = (r_state == ACK);
  assign o_busy = (r_state != IDLE);

endmodule

// File: tb/tb_crossbar_mem_slave.sv
// Self-checking bench: one instance with two wait states, one with none.
module tb_crossbar_mem_slave;

  logic        clk;
  logic        rst;
  logic        req, cmd, ack, busy;
  logic [31:0] addr, wdata, rdata;
  logic        req0, cmd0, ack0, busy0;
  logic [31:0] addr0, wdata0, rdata0;

  int checks;
  int failures;

  logic [31:0] model [256];
  bit          known [256];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cmd;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs [6];

  crossbar_mem_slave #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .i_wdata(wdata),
    .i_cmd(cmd), .o_ack(ack), .o_rdata(rdata), .o_busy(busy)
  );

  crossbar_mem_slave #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .i_req(req0), .i_addr(addr0), .i_wdata(wdata0),
    .i_cmd(cmd0), .o_ack(ack0), .o_rdata(rdata0), .o_busy(busy0)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something never returns.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  // One clean transaction on the two-wait-state instance; returns ack latency
  // in cycles after the capture edge (0 on timeout) and rdata seen with ack.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic c,
                               output logic [31:0] rd, output int lat);
    @(negedge clk);
    req = 1'b1; addr = a; wdata = d; cmd = c;
    lat = 0;
    rd  = '0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack) begin
        lat = n;
        rd  = rdata;
        break;
      end
    end
    req = 1'b0;
    @(negedge clk);
    checkOutput("post_ack_ack", {31'd0, ack}, 32'd0);
    checkOutput("post_ack_rdata", rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a, d;
    logic        c;
    int          lat;

    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) known[i] = 1'b0;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[1] = '{32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0000_0400, 32'h0000_0011, 1'b1, 32'h0};
    vecs[3] = '{32'h0000_0000, 32'h0,         1'b0, 32'h0000_0011};
    vecs[4] = '{32'h0000_0020, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[5] = '{32'hFFFF_F023, 32'h0,         1'b0, 32'hDEAD_BEEF};

    rst = 1'b1;
    req = 0; addr = 0; wdata = 0; cmd = 0;
    req0 = 0; addr0 = 0; wdata0 = 0; cmd0 = 0;
    #12;
    checkOutput("reset_ack",    {31'd0, ack},  32'd0);
    checkOutput("reset_busy",   {31'd0, busy}, 32'd0);
    checkOutput("reset_rdata",  rdata,         32'd0);
    checkOutput("reset_ack0",   {31'd0, ack0}, 32'd0);
    checkOutput("reset_rdata0", rdata0,        32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven basic and aliasing accesses.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].cmd, rd, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, 32'd3);
      if (vecs[i].cmd == 1'b0) begin
        checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRdata);
      end else begin
        model[vecs[i].addr[9:2]] = vecs[i].wdata;
        known[vecs[i].addr[9:2]] = 1'b1;
      end
    end

    // Abort: drop req during the first wait cycle.
    @(negedge clk);
    req = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; cmd = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy_wait", {31'd0, busy}, 32'd1);
    req = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy_fall", {31'd0, busy}, 32'd0);
    checkOutput("abort_no_ack",    {31'd0, ack},  32'd0);
    applyStimulus(32'h20, 32'h0, 1'b0, rd, lat);
    checkOutput("abort_read_0x20", rd, 32'hDEAD_BEEF);

    // Master switch: address changes while req is held.
    @(negedge clk);
    req = 1'b1; addr = 32'h10; wdata = 32'h0BAD_F00D; cmd = 1'b1;
    @(negedge clk);
    addr = 32'h20; wdata = 32'hA5A5_A5A5;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack) begin
        lat = n;
        break;
      end
    end
    req = 1'b0;
    checkOutput("switch_latency", lat, 32'd3);
    @(negedge clk);
    model[8'h08] = 32'hA5A5_A5A5;
    applyStimulus(32'h20, 32'h0, 1'b0, rd, lat);
    checkOutput("switch_read_0x20", rd, 32'hA5A5_A5A5);
    applyStimulus(32'h10, 32'h0, 1'b0, rd, lat);
    checkOutput("switch_read_0x10", rd, 32'hDEAD_BEEF);

    // Asynchronous reset in the middle of a write's wait period.
    applyStimulus(32'h30, 32'hCAFE_F00D, 1'b1, rd, lat);
    model[8'h0C] = 32'hCAFE_F00D;
    known[8'h0C] = 1'b1;
    @(negedge clk);
    req = 1'b1; addr = 32'h30; wdata = 32'h0000_0099; cmd = 1'b1;
    @(negedge clk);
    checkOutput("rstwait_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstwait_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstwait_ack",  {31'd0, ack},  32'd0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    applyStimulus(32'h30, 32'h0, 1'b0, rd, lat);
    checkOutput("rstwait_read_0x30", rd, 32'hCAFE_F00D);

    // Asynchronous reset while a read is being acknowledged.
    @(negedge clk);
    req = 1'b1; addr = 32'h10; cmd = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstack_ack_before",   {31'd0, ack}, 32'd1);
    checkOutput("rstack_rdata_before", rdata, 32'hDEAD_BEEF);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstack_ack",   {31'd0, ack}, 32'd0);
    checkOutput("rstack_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; req = 1'b0;

    // Randomized clean transactions against the array model.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      a[9:2] = 8'(64 + $urandom_range(0, 7));
      d = $urandom;
      c = 1'($urandom_range(0, 1));
      applyStimulus(a, d, c, rd, lat);
      checkOutput($sformatf("rnd%0d_latency", i), lat, 32'd3);
      if (c) begin
        model[a[9:2]] = d;
        known[a[9:2]] = 1'b1;
      end else if (known[a[9:2]]) begin
        checkOutput($sformatf("rnd%0d_rdata", i), rd, model[a[9:2]]);
      end
    end

    // Zero-wait-state instance: single-cycle latency, then held req.
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h44; wdata0 = 32'h77; cmd0 = 1'b1;
    @(negedge clk);
    checkOutput("wc0_write_ack", {31'd0, ack0}, 32'd1);
    req0 = 1'b0;
    @(negedge clk);
    checkOutput("wc0_write_ack_clear", {31'd0, ack0}, 32'd0);
    req0 = 1'b1; addr0 = 32'h44; cmd0 = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      checkOutput($sformatf("wc0_hold_ack_%0d", n), {31'd0, ack0}, (n % 2 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wc0_hold_rdata_%0d", n), rdata0, (n % 2 == 1) ? 32'h77 : 32'd0);
    end
    req0 = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
